// File: rtl/usb_chk_pkg.sv
// Shared types and helpers for the USB RX sequence checker.
package usb_chk_pkg;

   // Checker state: HUNT searches for the sequence, LOCK tracks it and flags errors.
   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } chk_state_t;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] max_v;
      max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v >= max_v) ? max_v : v + 64'd1;
   endfunction

endpackage

// File: rtl/usb_rx_seq_checker_led_stretch.sv
// led_stretch: holds led low for HOLD cycles after the most recent trig pulse.
module led_stretch #(
   parameter int unsigned HOLD = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic led
);

   localparam int unsigned HW = $clog2(HOLD + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          led_q, led_d;

   // Reload on trigger, otherwise count down to zero; led mirrors the next count.
   always_comb begin
      hold_d = hold_q;
      if (trig) begin
         hold_d = HW'(HOLD);
      end else if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
      end
      led_d = (hold_d == '0);
   end

   // Hold counter and registered led.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         led_q  <= 1'b1;
      end else begin
         hold_q <= hold_d;
         led_q  <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/usb_rx_seq_checker.sv
// usb_rx_seq_checker: checks an incrementing modulo-2^DW byte stream, locks onto it,
// flags errors and keeps statistics. Statistics counters exist only when
// USB_RX_CHK_STATS_EN is defined; otherwise byte_cnt/err_cnt read 0.
module usb_rx_seq_checker
   import usb_chk_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LED_HOLD = 50000000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic             clr_stats,
   output logic             lock,
   output logic             err_pulse,
   output logic             led,
   output logic [CNT_W-1:0] byte_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

   chk_state_t       state_q, state_d;
   logic [DW-1:0]    exp_q, exp_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             miss_q, miss_d;
   logic             in_ready_q;
   logic             lock_q, lock_d;
   logic             err_pulse_q;
   logic             hs;
   logic             match;
   logic             err;

   assign hs    = in_valid & in_ready_q;
   assign match = (in_data == exp_q);

   // Sequence tracking FSM: next state, expected word, run/miss counters and error flag.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      run_d   = run_q;
      miss_d  = miss_q;
      err     = 1'b0;
      if (hs) begin
         exp_d = in_data + DW'(1);
         case (state_q)
            HUNT: begin
               if (!match) begin
                  run_d = '0;
               end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                  state_d = LOCK;
                  run_d   = '0;
               end else begin
                  run_d = run_q + RUN_W'(1);
               end
            end
            LOCK: begin
               if (match) begin
                  miss_d = 1'b0;
               end else begin
                  err = 1'b1;
                  if (miss_q) begin
                     state_d = HUNT;
                     run_d   = '0;
                     miss_d  = 1'b0;
                  end else begin
                     miss_d = 1'b1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
      lock_d = (state_d == LOCK);
   end

   // State registers; in_ready rises on the first edge after reset and stays high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         exp_q       <= '0;
         run_q       <= '0;
         miss_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         lock_q      <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         in_ready_q  <= 1'b1;
         lock_q      <= lock_d;
         err_pulse_q <= err;
      end
   end

   assign in_ready  = in_ready_q;
   assign lock      = lock_q;
   assign err_pulse = err_pulse_q;

   led_stretch #(
      .HOLD(LED_HOLD)
   ) u_led_stretch (
      .clk (clk),
      .rst (rst),
      .trig(err),
      .led (led)
   );

`ifdef USB_RX_CHK_STATS_EN
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Statistics: clear wins over hold, but an event in the clear cycle still counts as 1.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (clr_stats) begin
         byte_cnt_d = hs  ? CNT_W'(1) : '0;
         err_cnt_d  = err ? CNT_W'(1) : '0;
      end else begin
         if (hs) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end
         if (err) begin
            err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign byte_cnt = byte_cnt_q;
   assign err_cnt  = err_cnt_q;
`else
   logic unused_clr_stats;
   assign unused_clr_stats = clr_stats;
   assign byte_cnt         = '0;
   assign err_cnt          = '0;
`endif

endmodule

// File: doc/usb_rx_seq_checker.md
# usb_rx_seq_checker

Receive-side stream checker sitting directly downstream of the `ftdi_245fifo` RX port on the FPGA side. It consumes the valid/ready byte stream from the host, verifies it is a modulo-2^DW incrementing sequence, locks onto the sequence after a run of good words, and counts accepted words and errors. It drives a stretched error indicator for the board LED. It replaces ad-hoc checker logic in top-level test designs.

## Interface
- `DW`, 8: stream data width in bits.
- `LOCK_CNT`, 4: consecutive matching words required to enter LOCK (≥1).
- `LED_HOLD`, 50000000: cycles `led` stays low after an error (≥1).
- `CNT_W`, 32: width of statistics counters.
- `clk`  in  1  single clock for all logic (the ftdi_245fifo `rx_clk` domain).
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  checker ready; a handshake occurs when `in_valid & in_ready`.
- `in_data`  in  DW  upstream word.
- `clr_stats`  in  1  one-cycle synchronous clear of `byte_cnt` / `err_cnt`.
- `lock`  out  1  high while the state is LOCK.
- `err_pulse`  out  1  one-cycle pulse per detected error.
- `led`  out  1  high = no error within the last LED_HOLD cycles.
- `byte_cnt`  out  CNT_W  accepted words, wraps.
- `err_cnt`  out  CNT_W  errors, saturates at all-ones.

## Operation
- Reset values: `in_ready`=0, `lock`=0, `err_pulse`=0, `led`=1, `byte_cnt`=0, `err_cnt`=0. Internal: state=HUNT, `expect`=0, `run`=0, `miss`=0, hold counter=0.
- `in_ready` is registered. It is 1 from the first cycle after `rst` deasserts and is never throttled afterwards.
- Every handshake: `expect` <= `in_data`+1, truncated to DW bits, so 0xFF is followed by 0x00. `byte_cnt` increments.
- HUNT state:
  - match (`in_data`==`expect`): `run`+1.
  - mismatch: `run`=0.
  - A match with `run`==LOCK_CNT-1 moves to LOCK and clears `run`.
  - No errors are flagged in HUNT.
- LOCK state:
  - match: `miss`=0.
  - mismatch: error is flagged. `err_pulse`=1, `err_cnt`+1 (saturating), hold counter loaded with LED_HOLD, `miss`+1.
  - A second consecutive mismatch (`miss` was 1) also flags an error, then moves to HUNT with `run`=0 and `miss`=0.
- `led` = (hold counter == 0). The hold counter decrements by 1 per cycle when nonzero. A new error during the hold reloads LED_HOLD.
- `clr_stats` zeroes both counters.
  - Simultaneous with a handshake: `byte_cnt`=1.
  - Simultaneous with an error: `err_cnt`=1.
  - `clr_stats` does not affect state, `expect`, or `led`.
- `rst` mid-stream returns every register to its reset value on the next edge. A handshake in the reset cycle is ignored.

## Timing
- All outputs are registered.
- `err_pulse`, `led` fall, `lock` change and counter updates appear one cycle after the causing handshake.
- Sustained throughput is one word per cycle with zero back-pressure.
- The earliest `lock` assertion is LOCK_CNT handshakes after reset, visible on the cycle after the LOCK_CNT-th handshake.
- `led` stays low for exactly LED_HOLD cycles after the last error.

## Configuration
- `USB_RX_CHK_STATS_EN` defined: `byte_cnt` and `err_cnt` registers and `clr_stats` logic are built as described.
- Not defined: `byte_cnt` and `err_cnt` are constant 0 and `clr_stats` is ignored.
- `lock`, `err_pulse` and `led` behave identically with or without the macro.

## Structure
- `usb_chk_pkg` holds:
  - the `chk_state_t` enum {HUNT, LOCK};
  - a saturating-increment function used by `err_cnt`.
- Sub-module `led_stretch` (params `HOLD`; ports `clk`, `rst`, `trig`, `led`) implements the hold counter. It is reusable for other status LEDs.

## Test plan
- Reset, then send 0x00..0x0F continuously:
  - `in_ready`=1 from the first post-reset cycle;
  - `lock` rises one cycle after the 4th handshake;
  - `err_cnt`=0, `byte_cnt`=16, `led`=1.
- Locked at expect 0x20, send 0x20, 0x55, 0x56:
  - one `err_pulse` one cycle after the 0x55 handshake;
  - `err_cnt`=1, `lock` stays 1;
  - `led` low for LED_HOLD (set to 10) cycles, then high.
- Locked, send 0x30, 0x99, 0x10:
  - two errors (`err_cnt`=2);
  - `lock`=0 one cycle after the 0x10 handshake;
  - resend 0x11..0x14 → `lock`=1 again.
- Send 0xFD, 0xFE, 0xFF, 0x00, 0x01 with DW=8 while locked → no error across the wrap.
- Assert `clr_stats` in the same cycle as a mismatching handshake while locked → `err_cnt`=1, `byte_cnt`=1.
- Assert `rst` for 1 cycle mid-stream while `led`=0 → the next cycle shows all reset values (`lock`=0, `led`=1, counters 0).
